// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encoding plus the grant-index width helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4,
        S_HOLD      = 3'd5
    } state_e;

    localparam int CNT_W = 16;

    function automatic int gnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping around. Reusable by any arbiter with N requesters.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = gnt_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    int          s;
    logic [W-1:0] j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        s     = 0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = int'(ptr) + i;
            if (s >= N) s = s - N;
            j = W'(s);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte streams,
// locking the grant until the owner sends a byte flagged last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16,
    localparam int GW          = gnt_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_tx_en,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] TO_LAST  =
        CNT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic               active_q, active_d;
    logic               terr_q, terr_d;
    logic               en_q, en_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;

    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic [7:0]         req_bytes [NUM_REQ];
    logic [GW-1:0]      next_ptr;
    logic               resolve;
    logic               rel;
    logic               fetch;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    rr_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        last_d   = last_q;
        data_d   = data_q;
        active_d = active_q;
        terr_d   = 1'b0;
        resolve  = 1'b0;
        rel      = 1'b0;
        fetch    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_found && !uart_tx_busy) begin
                    grant_d  = pick_idx;
                    data_d   = req_bytes[pick_idx];
                    last_d   = req_last[pick_idx];
                    active_d = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    terr_d = 1'b1;
                    rel    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) resolve = 1'b1;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_HOLD: begin
                if (req_valid[grant_q] && !uart_tx_busy) fetch = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A launch is only issued with the transmitter idle.
        if (resolve) begin
            if (last_q) rel = 1'b1;
            else if (req_valid[grant_q] && !uart_tx_busy) fetch = 1'b1;
            else state_d = S_HOLD;
        end

        if (rel) begin
            active_d = 1'b0;
            rr_ptr_d = next_ptr;
            state_d  = S_IDLE;
        end

        if (fetch) begin
            data_d  = req_bytes[grant_q];
            last_d  = req_last[grant_q];
            state_d = S_LAUNCH;
        end

        en_d    = (state_d == S_LAUNCH);
        ready_d = en_d ? (NUM_REQ'(1) << grant_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            last_q   <= 1'b0;
            data_q   <= '0;
            active_q <= 1'b0;
            terr_q   <= 1'b0;
            en_q     <= 1'b0;
            ready_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            data_q   <= data_d;
            active_q <= active_d;
            terr_q   <= terr_d;
            en_q     <= en_d;
            ready_q  <= ready_d;
        end
    end

    assign req_ready    = ready_q;
    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign grant_id     = grant_q;
    assign active       = active_q;
    assign timeout_err  = terr_q;

endmodule
